// File: rtl/seven_seg_scan_ctrl_if.sv
// Load/display bundle between the result register, the scan controller and the board pins.
// blink_mask is present only when SEG_SCAN_BLINK_EN is defined.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DUTY_BITS  = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] number;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [DUTY_BITS-1:0]    brightness;
`ifdef SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_mask;
`endif
    logic                    load_ack;
    logic                    frame_start;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output load, number, dp_in, blank_lz, brightness,
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask,
`endif
        input  load_ack, frame_start, seg_out, dp_out, an
    );

    modport slave (
        input  load, number, dp_in, blank_lz, brightness,
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask,
`endif
        output load_ack, frame_start, seg_out, dp_out, an
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: frame-synchronous load, leading-zero blanking,
// PWM dimming and a per-slot anti-ghosting guard. Define SEG_SCAN_BLINK_EN for per-digit blinking.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 800,
    parameter int DUTY_BITS  = 4,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_HZ   = 2
) (
    input logic                  clk,
    input logic                  rst,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int SLOT_W = $clog2(DIV);
    localparam int DIG_W  = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD_LEN = SLOT_W'(GUARD);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    // Output level that means "off" for an, seg_out and dp_out.
    localparam logic OFF = (ACTIVE_LOW != 0);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || DIV < 8 || GUARD < 0 || GUARD >= DIV ||
        DUTY_BITS < 1 || BLINK_HZ < 1) begin : g_param_check
        $error("seven_seg_scan_ctrl: illegal parameter combination");
    end

    function automatic logic [6:0] font_low(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [DUTY_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [4*NUM_DIGITS-1:0] pend_num_q, pend_num_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [4*NUM_DIGITS-1:0] act_num_q, act_num_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                    frame_start_q, frame_start_d;
    logic                    load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    slot_wrap;
    logic                    frame_wrap;
    logic                    in_guard;
    logic                    lit;
    logic [3:0]              cur_val;

    logic [3:0]              act_digit [NUM_DIGITS];
    logic [NUM_DIGITS:1]     zero_from;
    logic [NUM_DIGITS-1:0]   lz_hide;
    logic [NUM_DIGITS-1:0]   blink_hide;
    logic [NUM_DIGITS-1:0]   hide;

    genvar gi;

    // zero_from[i]: every active digit j >= i is 0 with its dp clear.
    assign zero_from[NUM_DIGITS] = 1'b1;
    assign lz_hide[0]            = 1'b0;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign act_digit[gi] = act_num_q[4*gi +: 4];
        if (gi > 0) begin : g_lz
            assign zero_from[gi] = zero_from[gi+1] && (act_num_q[4*gi +: 4] == 4'h0) &&
                                   !act_dp_q[gi];
            assign lz_hide[gi]   = bus.blank_lz && zero_from[gi];
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_hide = blink_on_q ? '0 : bus.blink_mask;
`else
    assign blink_hide = '0;
`endif

    assign hide = lz_hide | blink_hide;

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_wrap = slot_wrap && (digit_q == DIG_LAST);

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end
        pwm_cnt_d = pwm_cnt_q + 1'b1;

        // At the boundary pending moves to active first; a load in the same cycle re-arms pending.
        act_num_d   = act_num_q;
        act_dp_d    = act_dp_q;
        pend_num_d  = pend_num_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        if (frame_wrap && pend_flag_q) begin
            act_num_d   = pend_num_q;
            act_dp_d    = pend_dp_q;
            pend_flag_d = 1'b0;
        end
        if (bus.load) begin
            pend_num_d  = bus.number;
            pend_dp_d   = bus.dp_in;
            pend_flag_d = 1'b1;
        end

        frame_start_d = frame_wrap;
        load_ack_d    = frame_wrap && pend_flag_q;

        in_guard = (slot_cnt_q < GUARD_LEN);
        cur_val  = act_digit[digit_q];
        lit      = !in_guard && (pwm_cnt_q <= bus.brightness) && !hide[digit_q];

        an_d = {NUM_DIGITS{OFF}};
        if (lit) begin
            an_d[digit_q] = ~OFF;
        end
        seg_d = {7{OFF}};
        dp_d  = OFF;
        if (!in_guard) begin
            seg_d = OFF ? font_low(cur_val) : ~font_low(cur_val);
            dp_d  = act_dp_q[digit_q] ? ~OFF : OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            pwm_cnt_q     <= '0;
            pend_num_q    <= '0;
            pend_dp_q     <= '0;
            pend_flag_q   <= 1'b0;
            act_num_q     <= '0;
            act_dp_q      <= '0;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
            an_q          <= {NUM_DIGITS{OFF}};
            seg_q         <= {7{OFF}};
            dp_q          <= OFF;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pend_num_q    <= pend_num_d;
            pend_dp_q     <= pend_dp_d;
            pend_flag_q   <= pend_flag_d;
            act_num_q     <= act_num_d;
            act_dp_q      <= act_dp_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg_out     = seg_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_start = frame_start_q;
    assign bus.load_ack    = load_ack_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4 digits, 16-cycle slots, 2-cycle guard, active-low.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND), .DUTY_BITS(2)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND), .CLK_HZ(1600), .SCAN_HZ(100), .DUTY_BITS(2),
        .GUARD(2), .ACTIVE_LOW(1), .BLINK_HZ(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0]      num;
        logic [3:0]       dp;
        logic             blz;
        logic [1:0]       bri;
        logic [3:0][6:0]  seg;    // expected active-low font per digit, [3] = leftmost
        logic [3:0]       blank;  // digits whose anode must stay off all slot
    } vec_t;

    vec_t       vecs [8];
    vec_t       v;
    int         checks = 0;
    int         errors = 0;
    int         n;
    logic [3:0] cap_an  [64];
    logic [6:0] cap_seg [64];
    logic       cap_dp  [64];
    logic       cap_ack [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic chk_n(input string name, input int nbad, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first got %0h want %0h", name, nbad, got, want);
        end else begin
            $display("ok   %s", name);
        end
    endtask

    task automatic do_load(input logic [15:0] num, input logic [3:0] dp);
        bus.number = num;
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic count_to_frame(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.frame_start !== 1'b1 && cnt < 200);
    endtask

    task automatic wait_frame(input logic exp_ack, input string name);
        int cnt;
        count_to_frame(cnt);
        chk({name, "_frame_start"}, 32'(bus.frame_start), 32'd1);
        chk({name, "_load_ack"}, 32'(bus.load_ack), 32'(exp_ack));
    endtask

    // Sample k holds the output for digit k/16, slot cycle k%16; the last one is the next frame_start.
    task automatic capture();
        for (int k = 0; k < 64; k++) begin
            tick();
            cap_an[k]  = bus.an;
            cap_seg[k] = bus.seg_out;
            cap_dp[k]  = bus.dp_out;
            cap_ack[k] = bus.load_ack;
        end
    endtask

    task automatic check_frame(input vec_t e, input string tag);
        int nstray;
        nstray = 0;
        for (int k = 0; k < 63; k++) if (cap_ack[k] !== 1'b0) nstray++;
        chk_n({tag, "_no_stray_ack"}, nstray, 32'd1, 32'd0);
        for (int d = 0; d < ND; d++) begin
            int         bad_g, bad_a, bad_s;
            logic [31:0] g_got, g_want, a_got, a_want, s_got, s_want;
            logic [3:0] sel, exp_an;
            logic       on;
            bad_g = 0; bad_a = 0; bad_s = 0;
            g_got = 0; g_want = 0; a_got = 0; a_want = 0; s_got = 0; s_want = 0;
            sel = 4'b0001 << d;
            for (int s = 0; s < 16; s++) begin
                int k;
                k = 16 * d + s;
                if (s < 2) begin
                    if ({cap_an[k], cap_seg[k], cap_dp[k]} !== {4'hF, 7'h7F, 1'b1}) begin
                        if (bad_g == 0) begin
                            g_got  = 32'({cap_an[k], cap_seg[k], cap_dp[k]});
                            g_want = 32'({4'hF, 7'h7F, 1'b1});
                        end
                        bad_g++;
                    end
                end else begin
                    on     = !e.blank[d] && ((s % 4) <= int'(e.bri));
                    exp_an = on ? ~sel : 4'hF;
                    if (cap_an[k] !== exp_an) begin
                        if (bad_a == 0) begin a_got = 32'(cap_an[k]); a_want = 32'(exp_an); end
                        bad_a++;
                    end
                    if (on && {cap_seg[k], cap_dp[k]} !== {e.seg[d], ~e.dp[d]}) begin
                        if (bad_s == 0) begin
                            s_got  = 32'({cap_seg[k], cap_dp[k]});
                            s_want = 32'({e.seg[d], ~e.dp[d]});
                        end
                        bad_s++;
                    end
                end
            end
            chk_n($sformatf("%s_d%0d_guard", tag, d), bad_g, g_got, g_want);
            chk_n($sformatf("%s_d%0d_an", tag, d), bad_a, a_got, a_want);
            chk_n($sformatf("%s_d%0d_seg_dp", tag, d), bad_s, s_got, s_want);
        end
    endtask

    initial begin
        vecs[0] = '{num: 16'h12AF, dp: 4'b0100, blz: 1'b0, bri: 2'd3,
                    seg: {7'h79, 7'h24, 7'h08, 7'h0E}, blank: 4'b0000};
        vecs[1] = '{num: 16'h0030, dp: 4'b0000, blz: 1'b1, bri: 2'd3,
                    seg: {7'h40, 7'h40, 7'h30, 7'h40}, blank: 4'b1100};
        vecs[2] = '{num: 16'h0000, dp: 4'b0000, blz: 1'b1, bri: 2'd3,
                    seg: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b1110};
        vecs[3] = '{num: 16'h0030, dp: 4'b0100, blz: 1'b1, bri: 2'd3,
                    seg: {7'h40, 7'h40, 7'h30, 7'h40}, blank: 4'b1000};
        vecs[4] = '{num: 16'h3456, dp: 4'b0000, blz: 1'b0, bri: 2'd1,
                    seg: {7'h30, 7'h19, 7'h12, 7'h02}, blank: 4'b0000};
        vecs[5] = '{num: 16'h789C, dp: 4'b0001, blz: 1'b1, bri: 2'd0,
                    seg: {7'h78, 7'h00, 7'h10, 7'h46}, blank: 4'b0000};
        vecs[6] = '{num: 16'h0EDB, dp: 4'b0000, blz: 1'b1, bri: 2'd2,
                    seg: {7'h40, 7'h06, 7'h21, 7'h03}, blank: 4'b1000};
        vecs[7] = '{num: 16'h0000, dp: 4'b1000, blz: 1'b0, bri: 2'd3,
                    seg: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b0000};

        bus.load       = 1'b0;
        bus.number     = '0;
        bus.dp_in      = '0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 2'd3;
`ifdef SEG_SCAN_BLINK_EN
        bus.blink_mask = '0;
`endif

        // Power-on reset values and distance to the first frame_start.
        tick(); tick(); tick();
        chk("por_an", 32'(bus.an), 32'hF);
        chk("por_seg", 32'(bus.seg_out), 32'h7F);
        chk("por_dp", 32'(bus.dp_out), 32'd1);
        chk("por_ack", 32'(bus.load_ack), 32'd0);
        chk("por_frame_start", 32'(bus.frame_start), 32'd0);
        rst = 1'b0;
        count_to_frame(n);
        chk("por_first_frame_cycles", 32'(n), 32'd64);
        chk("por_first_ack", 32'(bus.load_ack), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.blank_lz   = vecs[i].blz;
            bus.brightness = vecs[i].bri;
            do_load(vecs[i].num, vecs[i].dp);
            wait_frame(1'b1, $sformatf("v%0d", i));
            capture();
            check_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Two loads before one boundary: the later one wins, one ack only.
        bus.blank_lz   = 1'b0;
        bus.brightness = 2'd3;
        do_load(16'h1111, 4'b0000);
        tick();
        do_load(16'h2222, 4'b0000);
        wait_frame(1'b1, "lastwins");
        capture();
        v = '{num: 16'h2222, dp: 4'b0000, blz: 1'b0, bri: 2'd3,
              seg: {7'h24, 7'h24, 7'h24, 7'h24}, blank: 4'b0000};
        check_frame(v, "lastwins");
        chk("lastwins_second_boundary_ack", 32'(cap_ack[63]), 32'd0);

        // A load in the wrap cycle itself waits for the following boundary.
        for (int i = 0; i < 63; i++) tick();
        do_load(16'h5555, 4'b0000);
        chk("bnd_frame_start", 32'(bus.frame_start), 32'd1);
        chk("bnd_ack_deferred", 32'(bus.load_ack), 32'd0);
        wait_frame(1'b1, "bnd_next");
        capture();
        v = '{num: 16'h5555, dp: 4'b0000, blz: 1'b0, bri: 2'd3,
              seg: {7'h12, 7'h12, 7'h12, 7'h12}, blank: 4'b0000};
        check_frame(v, "bnd");

        // Mid-slot asynchronous reset with a load pending.
        do_load(16'h9999, 4'b1111);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_an", 32'(bus.an), 32'hF);
        chk("mid_rst_seg", 32'(bus.seg_out), 32'h7F);
        chk("mid_rst_dp", 32'(bus.dp_out), 32'd1);
        chk("mid_rst_ack", 32'(bus.load_ack), 32'd0);
        tick(); tick();
        rst = 1'b0;
        count_to_frame(n);
        chk("mid_rst_frame_cycles", 32'(n), 32'd64);
        chk("mid_rst_pending_dropped", 32'(bus.load_ack), 32'd0);
        capture();
        v = '{num: 16'h0000, dp: 4'b0000, blz: 1'b0, bri: 2'd3,
              seg: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b0000};
        check_frame(v, "mid_rst_cleared");

`ifdef SEG_SCAN_BLINK_EN
        // Blink windows line up with slots from reset: digit 1 always lands in an off window.
        bus.blink_mask = 4'b0011;
        do_load(16'h4321, 4'b0000);
        wait_frame(1'b1, "blink");
        capture();
        v = '{num: 16'h4321, dp: 4'b0000, blz: 1'b0, bri: 2'd3,
              seg: {7'h19, 7'h30, 7'h24, 7'h79}, blank: 4'b0010};
        check_frame(v, "blink");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
